// File: rtl/tortoise_pkg.sv
// -----------------------------------------------------------------------------
// tortoise_pkg
// Shared core types and defaults used by the decoder, the issue queue and the
// ScoreBoard.
//   scoreboard_entry_t  : one decoded instruction, with a per-slot valid bit
//   INSTR_PER_FETCH     : instructions per decoded group
//   DEFAULT_ISSUE_WIDTH : default number of issue lanes
//   DEFAULT_DEPTH       : default issue queue capacity
// -----------------------------------------------------------------------------
package tortoise_pkg;

    localparam int unsigned INSTR_PER_FETCH     = 2;
    localparam int unsigned DEFAULT_ISSUE_WIDTH = 2;
    localparam int unsigned DEFAULT_DEPTH       = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [7:0]  op;
    } scoreboard_entry_t;

endpackage

// File: rtl/issue_queue_if.sv
// -----------------------------------------------------------------------------
// issue_queue_if
// Bundles the decoder-side load handshake and the ScoreBoard-side issue lanes
// of the issue queue.
//   instr_valid_i / instr_i / instr_load_o : decoded group offer and accept
//   issue_valid_o / issue_instr_o          : in-order issue lanes
//   issue_ack_i                            : lanes consumed this cycle
//   count_o                                : queue occupancy
// modport slave  : the issue queue
// modport master : the decoder/ScoreBoard side driving it
// -----------------------------------------------------------------------------
interface issue_queue_if #(
    parameter int unsigned NR_ENTRIES  = tortoise_pkg::INSTR_PER_FETCH,
    parameter int unsigned ISSUE_WIDTH = tortoise_pkg::DEFAULT_ISSUE_WIDTH,
    parameter int unsigned DEPTH       = tortoise_pkg::DEFAULT_DEPTH
);
    import tortoise_pkg::*;

    logic                                instr_valid_i;
    logic                                instr_load_o;
    scoreboard_entry_t [NR_ENTRIES-1:0]  instr_i;
    logic [ISSUE_WIDTH-1:0]              issue_valid_o;
    scoreboard_entry_t [ISSUE_WIDTH-1:0] issue_instr_o;
    logic [ISSUE_WIDTH-1:0]              issue_ack_i;
    logic [$clog2(DEPTH+1)-1:0]          count_o;

    modport slave (
        input  instr_valid_i, instr_i, issue_ack_i,
        output instr_load_o, issue_valid_o, issue_instr_o, count_o
    );

    modport master (
        output instr_valid_i, instr_i, issue_ack_i,
        input  instr_load_o, issue_valid_o, issue_instr_o, count_o
    );

endinterface

// File: rtl/issue_compact.sv
// -----------------------------------------------------------------------------
// issue_compact
// Combinational left-packer: moves the valid slots of a decoded group to the
// low positions, keeping slot order, and reports how many there are.
//   i_instr  : NR_ENTRIES slots, slot 0 oldest, per-slot .valid
//   o_packed : valid slots packed from position 0 upwards, rest zero
//   o_count  : number of valid slots
// -----------------------------------------------------------------------------
module issue_compact import tortoise_pkg::*; #(
    parameter int unsigned NR_ENTRIES = INSTR_PER_FETCH
) (
    input  scoreboard_entry_t [NR_ENTRIES-1:0] i_instr,
    output scoreboard_entry_t [NR_ENTRIES-1:0] o_packed,
    output logic [$clog2(NR_ENTRIES+1)-1:0]    o_count
);
    localparam int unsigned NW = $clog2(NR_ENTRIES + 1);

    logic [NR_ENTRIES-1:0] w_valid;
    // w_prefix[s] = number of valid slots older than s = destination of slot s
    logic [NW-1:0]         w_prefix [NR_ENTRIES];

    for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_slot
        localparam logic [NR_ENTRIES-1:0] OLDER_MASK = NR_ENTRIES'((1 << gi) - 1);
        assign w_valid[gi]  = i_instr[gi].valid;
        assign w_prefix[gi] = NW'($countones(w_valid & OLDER_MASK));
    end

    assign o_count = NW'($countones(w_valid));

    always_comb begin
        o_packed = '0;
        for (int p = 0; p < NR_ENTRIES; p++) begin
            for (int s = p; s < NR_ENTRIES; s++) begin
                if (w_valid[s] && (w_prefix[s] == NW'(p))) begin
                    o_packed[p] = i_instr[s];
                end
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
// Circular queue between decoder and ScoreBoard. Decoded groups are compacted
// on entry (invalid slots dropped); the oldest ISSUE_WIDTH instructions are
// presented in order on the issue lanes and retired by in-order acks.
//   clk_i        : clock
//   rst_i        : synchronous active-high reset
//   flush_i      : discard all buffered instructions
//   debug_mode_i : freeze the queue (no load, no issue)
//   bus          : issue_queue_if.slave (load handshake, issue lanes, count)
// -----------------------------------------------------------------------------
module issue_queue import tortoise_pkg::*; #(
    parameter int unsigned NR_ENTRIES  = INSTR_PER_FETCH,
    parameter int unsigned ISSUE_WIDTH = DEFAULT_ISSUE_WIDTH,
    parameter int unsigned DEPTH       = DEFAULT_DEPTH
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         debug_mode_i,
    issue_queue_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned NW = $clog2(NR_ENTRIES + 1);
    localparam int unsigned IW = $clog2(ISSUE_WIDTH + 1);

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < NR_ENTRIES) || (DEPTH < ISSUE_WIDTH)) begin : g_bad_params
        $error("issue_queue: DEPTH must be a power of two and >= NR_ENTRIES and >= ISSUE_WIDTH");
    end

    scoreboard_entry_t                  r_mem [DEPTH];
    logic [PW-1:0]                      r_head;
    logic [PW-1:0]                      r_tail;
    logic [CW-1:0]                      r_count;

    scoreboard_entry_t [NR_ENTRIES-1:0] w_packed;
    logic [NW-1:0]                      w_n_valid;
    logic [NW-1:0]                      w_n_loaded;
    logic [CW-1:0]                      w_free;
    logic                               w_load;
    logic [ISSUE_WIDTH-1:0]             w_issue_valid;
    logic [ISSUE_WIDTH-1:0]             w_acked;
    logic [ISSUE_WIDTH-1:0]             w_pop_mask;
    logic [IW-1:0]                      w_pop_n;
    logic [CW:0]                        w_count_sum;
    logic [CW-1:0]                      w_count_next;

    issue_compact #(.NR_ENTRIES(NR_ENTRIES)) u_compact (
        .i_instr  (bus.instr_i),
        .o_packed (w_packed),
        .o_count  (w_n_valid)
    );

    // Room is judged on the registered count only: a pop in the same cycle
    // does not open space for the incoming group. This also guarantees the
    // write region never overlaps the entries being popped.
    assign w_free     = CW'(DEPTH) - r_count;
    assign w_load     = bus.instr_valid_i & ~rst_i & ~flush_i & ~debug_mode_i
                      & (w_free >= CW'(NR_ENTRIES));
    assign w_n_loaded = w_load ? w_n_valid : '0;

    assign bus.instr_load_o = w_load;
    assign bus.count_o      = r_count;

    // Zero-latency lanes: lane k is a direct view of entry head+k.
    for (genvar gi = 0; gi < ISSUE_WIDTH; gi++) begin : g_lane
        logic [PW-1:0] w_idx;
        assign w_idx             = r_head + PW'(gi);
        assign w_issue_valid[gi] = (CW'(gi) < r_count) & ~debug_mode_i;
        assign bus.issue_instr_o[gi] = w_issue_valid[gi] ? r_mem[w_idx] : '0;
    end

    assign bus.issue_valid_o = w_issue_valid;
    assign w_acked           = bus.issue_ack_i & w_issue_valid;

    // Only the leading run of acked lanes retires; anything after a gap stays.
    always_comb begin
        logic run;
        run        = 1'b1;
        w_pop_mask = '0;
        w_pop_n    = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            run           = run & w_acked[k];
            w_pop_mask[k] = run;
            w_pop_n       = w_pop_n + IW'(run);
        end
    end

    assign w_count_sum  = {1'b0, r_count} + (CW+1)'(w_n_loaded);
    assign w_count_next = CW'(w_count_sum - (CW+1)'(w_pop_n));

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
        end else if (!debug_mode_i) begin
            for (int k = 0; k < ISSUE_WIDTH; k++) begin
                if (w_pop_mask[k]) begin
                    r_mem[r_head + PW'(k)] <= '0;
                end
            end
            for (int s = 0; s < NR_ENTRIES; s++) begin
                if (NW'(s) < w_n_loaded) begin
                    r_mem[r_tail + PW'(s)] <= w_packed[s];
                end
            end
            r_head  <= r_head + PW'(w_pop_n);
            r_tail  <= r_tail + PW'(w_n_loaded);
            r_count <= w_count_next;
        end
    end

    // Out-of-order ack: the later lanes are ignored, reported as a warning.
    a_ack_in_order: assert property (@(posedge clk_i) disable iff (rst_i)
        (w_acked & ~w_pop_mask) == '0)
        else $warning("issue_queue: ack after an unacknowledged lane ignored");

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i || flush_i || debug_mode_i)
        w_count_sum <= (CW+1)'(DEPTH));

    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i || flush_i || debug_mode_i)
        w_count_sum >= (CW+1)'(w_pop_n));

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
    import tortoise_pkg::*;

    localparam int NRE = 2;
    localparam int IWD = 2;
    localparam int DEP = 8;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic dbg;

    issue_queue_if #(.NR_ENTRIES(NRE), .ISSUE_WIDTH(IWD), .DEPTH(DEP)) bus ();

    issue_queue #(.NR_ENTRIES(NRE), .ISSUE_WIDTH(IWD), .DEPTH(DEP)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .debug_mode_i (dbg),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int unsigned tag = 1;

    // Reference model: plain FIFO of the instructions currently buffered.
    scoreboard_entry_t mq[$];

    typedef struct {
        bit       rst;
        bit       flush;
        bit       dbg;
        bit       iv;
        bit [1:0] sv;
        bit [1:0] ack;
        bit       e_load;
        bit [1:0] e_valid;
        int       e_count;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit f, bit d, bit iv, bit [1:0] sv, bit [1:0] ack,
                                bit el, bit [1:0] ev, int ec);
        vec_t v;
        v.rst = r; v.flush = f; v.dbg = d; v.iv = iv; v.sv = sv; v.ack = ack;
        v.e_load = el; v.e_valid = ev; v.e_count = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive at posedge+1, compare at negedge, update model at posedge.
    task automatic run_cycle(input bit r, input bit f, input bit d, input bit iv,
                             input bit [1:0] sv, input bit [1:0] ack,
                             output bit o_load, output bit [1:0] o_valid, output int o_count);
        scoreboard_entry_t [NRE-1:0] g;
        scoreboard_entry_t [IWD-1:0] e_i;
        bit [IWD-1:0] e_v;
        bit e_load;
        int sz;
        int pn;
        for (int s = 0; s < NRE; s++) begin
            g[s].valid = sv[s];
            g[s].pc    = tag;
            g[s].op    = 8'($urandom);
            tag++;
        end
        rst = r; flush = f; dbg = d;
        bus.instr_valid_i = iv;
        bus.instr_i       = g;
        bus.issue_ack_i   = ack;

        sz     = mq.size();
        e_load = iv && !r && !f && !d && ((DEP - sz) >= NRE);
        for (int k = 0; k < IWD; k++) begin
            e_v[k] = (k < sz) && !d;
            e_i[k] = e_v[k] ? mq[k] : '0;
        end
        pn = 0;
        for (int k = 0; k < IWD; k++) begin
            if (ack[k] && e_v[k]) pn++;
            else break;
        end

        @(negedge clk);
        chk("instr_load", 64'(bus.instr_load_o), 64'(e_load));
        chk("issue_valid", 64'(bus.issue_valid_o), 64'(e_v));
        chk("count", 64'(bus.count_o), 64'(sz));
        for (int k = 0; k < IWD; k++) begin
            chk($sformatf("lane%0d", k), 64'(bus.issue_instr_o[k]), 64'(e_i[k]));
        end
        o_load  = bus.instr_load_o;
        o_valid = bus.issue_valid_o;
        o_count = int'(bus.count_o);

        @(posedge clk);
        if (r || f) begin
            mq.delete();
        end else if (!d) begin
            repeat (pn) void'(mq.pop_front());
            if (e_load) begin
                for (int s = 0; s < NRE; s++) begin
                    if (g[s].valid) mq.push_back(g[s]);
                end
            end
        end
        #1;
    endtask

    initial begin
        bit ol;
        bit [1:0] ov;
        int oc;

        //               rst f d iv  sv     ack    load valid  count
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0)); // reset state
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b00, 1, 2'b00, 0)); // {v,v}
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 2));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b11, 0, 2'b11, 2)); // drain
        tbl.push_back(mk(0, 0, 0, 1, 2'b01, 2'b00, 1, 2'b00, 0)); // {v,0}
        tbl.push_back(mk(0, 0, 0, 1, 2'b10, 2'b00, 1, 2'b01, 1)); // {0,v}
        tbl.push_back(mk(0, 0, 0, 1, 2'b00, 2'b00, 1, 2'b11, 2)); // {0,0}
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 2));
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b00, 1, 2'b11, 2)); // fill
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b00, 1, 2'b11, 4));
        tbl.push_back(mk(0, 0, 0, 1, 2'b01, 2'b00, 1, 2'b11, 6));
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b01, 0, 2'b11, 7)); // no room, pop 1
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b00, 1, 2'b11, 6)); // loads now
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b00, 0, 2'b11, 8)); // full
        tbl.push_back(mk(0, 1, 0, 1, 2'b11, 2'b11, 0, 2'b11, 8)); // flush
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b00, 1, 2'b00, 0)); // walk head to 6
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b11, 1, 2'b11, 2));
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b11, 1, 2'b11, 2));
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b11, 1, 2'b11, 2));
        tbl.push_back(mk(0, 0, 0, 1, 2'b01, 2'b00, 1, 2'b11, 2)); // count 3, head 6
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b10, 0, 2'b11, 3)); // gap ack ignored
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b11, 0, 2'b11, 3)); // head wraps
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b00, 1, 2'b01, 1));
        tbl.push_back(mk(0, 0, 0, 1, 2'b01, 2'b00, 1, 2'b11, 3));
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b11, 1, 2'b11, 4)); // load+pop at 4
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 4));
        tbl.push_back(mk(0, 0, 1, 1, 2'b11, 2'b11, 0, 2'b00, 4)); // debug x3
        tbl.push_back(mk(0, 0, 1, 1, 2'b11, 2'b11, 0, 2'b00, 4));
        tbl.push_back(mk(0, 0, 1, 1, 2'b11, 2'b11, 0, 2'b00, 4));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 4)); // same lanes
        tbl.push_back(mk(1, 0, 0, 1, 2'b11, 2'b00, 0, 2'b11, 4)); // mid-stream reset
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b00, 1, 2'b00, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b11, 2));

        rst = 1'b1; flush = 1'b0; dbg = 1'b0;
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = '0;
        bus.issue_ack_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete();

        foreach (tbl[i]) begin
            run_cycle(tbl[i].rst, tbl[i].flush, tbl[i].dbg, tbl[i].iv, tbl[i].sv, tbl[i].ack,
                      ol, ov, oc);
            chk($sformatf("row%0d load", i), 64'(ol), 64'(tbl[i].e_load));
            chk($sformatf("row%0d valid", i), 64'(ov), 64'(tbl[i].e_valid));
            chk($sformatf("row%0d count", i), 64'(oc), 64'(tbl[i].e_count));
            $display("row %0d: rst=%0d flush=%0d dbg=%0d iv=%0d sv=%b ack=%b -> load=%0d valid=%b count=%0d",
                     i, tbl[i].rst, tbl[i].flush, tbl[i].dbg, tbl[i].iv, tbl[i].sv, tbl[i].ack,
                     ol, ov, oc);
        end

        for (int c = 0; c < 1500; c++) begin
            bit r, f, d, iv;
            bit [1:0] sv, ack;
            int a;
            r   = ($urandom_range(0, 199) == 0);
            f   = ($urandom_range(0, 39) == 0);
            d   = ($urandom_range(0, 9) == 0);
            iv  = ($urandom_range(0, 3) != 0);
            sv  = 2'($urandom);
            a   = int'($urandom_range(0, 2));
            ack = (a == 0) ? 2'b00 : ((a == 1) ? 2'b01 : 2'b11);
            run_cycle(r, f, d, iv, sv, ack, ol, ov, oc);
            $display("rand %0d: rst=%0d flush=%0d dbg=%0d iv=%0d sv=%b ack=%b load=%0d valid=%b count=%0d",
                     c, r, f, d, iv, sv, ack, ol, ov, oc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
